rca_seq_add_ctrl: RTL

RCA_SEQ_ADD_CTRL -- requirements
Module: rca_seq_add_ctrl

---
 rtl/rca_seq_add_ctrl_pkg.sv | 19 +
 rtl/rca_seq_add_ctrl_if.sv | 29 ++
 rtl/RCA_adder.sv | 24 ++
 rtl/rca_seq_add_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/rca_seq_add_ctrl_pkg.sv
// Shared definitions for the sequential chunked ripple-carry adder:
// FSM state encoding, default geometry and the chunk-index width helper.
package rca_seq_add_ctrl_pkg;

    localparam int DEF_BIT_WIDTH  = 16;
    localparam int DEF_NUM_CHUNKS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the chunk index: clog2 of the chunk count, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_seq_add_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer (master)
// and the sequential adder (slave).
interface rca_seq_add_ctrl_if
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS
);
    logic                             in_valid;
    logic                             in_ready;
    logic [BIT_WIDTH*NUM_CHUNKS-1:0]  add_1;
    logic [BIT_WIDTH*NUM_CHUNKS-1:0]  add_2;
    logic                             c_in;
    logic                             out_valid;
    logic                             out_ready;
    logic [BIT_WIDTH*NUM_CHUNKS-1:0]  sum;
    logic                             c_out;
    logic                             busy;

    modport master (
        output in_valid, add_1, add_2, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );

    modport slave (
        input  in_valid, add_1, add_2, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
endinterface

// File: rtl/RCA_adder.sv
// Plain ripple-carry adder used as the shared chunk datapath.
module RCA_adder #(
    parameter int BIT_WIDTH = 16
) (
    input  logic [BIT_WIDTH-1:0] a_i,
    input  logic [BIT_WIDTH-1:0] b_i,
    input  logic                 c_i,
    output logic [BIT_WIDTH-1:0] s_o,
    output logic                 c_o
);
    logic [BIT_WIDTH:0] carry;

    // Bit-serial carry ripple through full-adder cells.
    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c_i;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = carry[BIT_WIDTH];
    end
endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Wide unsigned adder built from one BIT_WIDTH adder reused over NUM_CHUNKS
// cycles. Operands are captured on accept, chunks are added LSB first with
// the carry held in a register, and the result is held until consumed.
module rca_seq_add_ctrl
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               rst_n,
    rca_seq_add_ctrl_if.slave  bus
);
    localparam int              W      = BIT_WIDTH * NUM_CHUNKS;
    localparam int              KW     = idx_width(NUM_CHUNKS);
    localparam logic [KW-1:0]   K_LAST = KW'(NUM_CHUNKS - 1);

    state_t                state_q;
    logic [KW-1:0]         k_q;
    logic                  carry_q;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [W-1:0]          res_q;
    logic [W-1:0]          res_d;
    logic [W-1:0]          sum_q;
    logic                  c_out_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [BIT_WIDTH-1:0]  chunk_a;
    logic [BIT_WIDTH-1:0]  chunk_b;
    logic [BIT_WIDTH-1:0]  chunk_sum;
    logic                  chunk_cout;

    assign chunk_a = a_q[k_q*BIT_WIDTH +: BIT_WIDTH];
    assign chunk_b = b_q[k_q*BIT_WIDTH +: BIT_WIDTH];

    RCA_adder #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_adder (
        .a_i (chunk_a),
        .b_i (chunk_b),
        .c_i (carry_q),
        .s_o (chunk_sum),
        .c_o (chunk_cout)
    );

    // Result with the current chunk merged in; committed at the end of each ADD cycle.
    always_comb begin
        res_d = res_q;
        res_d[k_q*BIT_WIDTH +: BIT_WIDTH] = chunk_sum;
    end

    // Control FSM with registered handshake/status outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.add_1;
                        b_q        <= bus.add_2;
                        carry_q    <= bus.c_in;
                        k_q        <= '0;
                        state_q    <= ST_ADD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ADD: begin
                    res_q   <= res_d;
                    carry_q <= chunk_cout;
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_q     <= ST_DONE;
                        sum_q       <= res_d;
                        c_out_q     <= chunk_cout;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // The return to IDLE is its own cycle, so no accept can coincide with it.
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
endmodule
